hpc3_rand_source: RTL and testbench

HPC3_RAND_SOURCE -- requirements
Module: hpc3_rand_source

---
 rtl/aes128_package.sv | 28 ++
 rtl/lfsr_multi_step.sv | 20 ++
 rtl/hpc3_rand_source.sv | 118 +++++++++++
 tb/tb_hpc3_rand_source.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_package.sv
// Shared constants and helpers for the HPC3 randomness source.
//   LFSR_WIDTH : width of the seeded LFSR state
//   LFSR_TAPS  : feedback tap mask (bits 63, 62, 60, 59)
//   rand_state_e : UNSEEDED / WARMUP / RUN controller states
//   num_quad(n)  : cross-share pair count of an n-share HPC3 multiplier
//   rand_bits(n, w) : total random bits (R and P) per multiplication
package aes128_package;

   localparam int unsigned LFSR_WIDTH = 64;

   // Feedback is the XOR of state bits 63, 62, 60 and 59.
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   typedef enum logic [1:0] {
      StUnseeded,
      StWarmup,
      StRun
   } rand_state_e;

   function automatic int unsigned num_quad(input int unsigned n);
      return (n * (n - 1)) / 2;
   endfunction

   function automatic int unsigned rand_bits(input int unsigned n, input int unsigned w);
      return 2 * num_quad(n) * w;
   endfunction

endpackage

// File: rtl/lfsr_multi_step.sv
// Combinational STEPS-fold advance of the 64-bit Fibonacci LFSR.
//   in_state  : current LFSR state
//   out_state : state after STEPS single-bit shifts
module lfsr_multi_step
   import aes128_package::*;
#(
   parameter int unsigned STEPS = 1
) (
   input  logic [LFSR_WIDTH-1:0] in_state,
   output logic [LFSR_WIDTH-1:0] out_state
);

   always_comb begin
      out_state = in_state;
      for (int unsigned i = 0; i < STEPS; i++) begin
         out_state = {out_state[LFSR_WIDTH-2:0], ^(out_state & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/hpc3_rand_source.sv
// Seeded LFSR randomness source feeding one HPC3 masked multiplier.
//   in_clock / in_reset         : clock, asynchronous active-low reset
//   in_seed / in_seed_valid     : seed offer, accepted in any state
//   out_seed_ready              : high whenever out of reset
//   in_enable                   : consumer takes current randomness, requests fresh
//   out_r / out_p               : blinding and correction randomness
//   out_valid                   : out_r / out_p are fresh and usable
module hpc3_rand_source
   import aes128_package::*;
#(
   parameter int unsigned NUM_SHARES    = 2,
   parameter int unsigned BIT_WIDTH     = 2,
   parameter int unsigned WARMUP_CYCLES = 16
) (
   input  logic                                      in_clock,
   input  logic                                      in_reset,
   input  logic [LFSR_WIDTH-1:0]                     in_seed,
   input  logic                                      in_seed_valid,
   output logic                                      out_seed_ready,
   input  logic                                      in_enable,
   output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0] out_r,
   output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0] out_p,
   output logic                                      out_valid
);

   localparam int unsigned HALF  = num_quad(NUM_SHARES) * BIT_WIDTH;
   localparam int unsigned K     = rand_bits(NUM_SHARES, BIT_WIDTH);
   localparam int unsigned CNT_W = $clog2(WARMUP_CYCLES + 1);

   if (K > LFSR_WIDTH) begin : gen_k_check
      $error("hpc3_rand_source: rand_bits exceeds the LFSR width");
   end
   if (WARMUP_CYCLES < 1) begin : gen_warmup_check
      $error("hpc3_rand_source: WARMUP_CYCLES must be at least 1");
   end

   rand_state_e           state_q, state_d;
   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_next;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  ready_q;
   logic                  seed_accept;

   lfsr_multi_step #(
      .STEPS(K)
   ) u_lfsr_multi_step (
      .in_state (lfsr_q),
      .out_state(lfsr_next)
   );

   assign seed_accept = in_seed_valid & ready_q;

   // State register
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state_q <= StUnseeded;
         lfsr_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ready_q <= 1'b1;
      end
   end

   // Next-state logic; a seed always restarts warmup, even over an enable in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StWarmup: begin
            if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
               state_d = StRun;
            end
         end
         StUnseeded, StRun: ;
         default: state_d = StUnseeded;
      endcase
      if (seed_accept) begin
         state_d = StWarmup;
      end
   end

   // Datapath control
   always_comb begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      if (seed_accept) begin
         // All-zero is the lock-up state of an XOR LFSR.
         lfsr_d = (in_seed == '0) ? LFSR_WIDTH'(1) : in_seed;
         cnt_d  = '0;
      end else begin
         case (state_q)
            StWarmup: begin
               lfsr_d = lfsr_next;
               cnt_d  = cnt_q + CNT_W'(1);
            end
            StRun: begin
               if (in_enable) begin
                  lfsr_d = lfsr_next;
               end
            end
            default: ;
         endcase
      end
      valid_d = (state_d == StRun);
   end

   // Outputs come straight from flops gated by the valid flop, so they cannot glitch.
   assign out_valid      = valid_q;
   assign out_seed_ready = ready_q;
   assign out_r          = lfsr_q[HALF-1:0] & {HALF{valid_q}};
   assign out_p          = lfsr_q[K-1:HALF] & {HALF{valid_q}};

endmodule

// File: tb/tb_hpc3_rand_source.sv
module tb_hpc3_rand_source;

   localparam int unsigned NS   = 2;
   localparam int unsigned BW   = 2;
   localparam int unsigned WU   = 16;
   localparam int unsigned HALF = ((NS * (NS - 1)) / 2) * BW;
   localparam int unsigned K    = 2 * HALF;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [63:0]     seed;
   logic            seed_valid;
   logic            seed_ready;
   logic            enable;
   logic [HALF-1:0] r, p;
   logic            valid;

   hpc3_rand_source #(
      .NUM_SHARES   (NS),
      .BIT_WIDTH    (BW),
      .WARMUP_CYCLES(WU)
   ) dut (
      .in_clock      (clk),
      .in_reset      (rst_n),
      .in_seed       (seed),
      .in_seed_valid (seed_valid),
      .out_seed_ready(seed_ready),
      .in_enable     (enable),
      .out_r         (r),
      .out_p         (p),
      .out_valid     (valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: seeded flag expressed as a warmup countdown.
   logic [63:0] m_lfsr;
   int          m_warm_left;
   bit          m_valid;
   bit          m_ready;

   function automatic logic [63:0] model_advance(input logic [63:0] s);
      logic [63:0] t;
      t = s;
      for (int i = 0; i < int'(K); i++) begin
         t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
      end
      return t;
   endfunction

   function automatic logic [K-1:0] model_out();
      return m_valid ? m_lfsr[K-1:0] : '0;
   endfunction

   task automatic apply_reset();
      rst_n       = 1'b0;
      m_lfsr      = '0;
      m_warm_left = 0;
      m_valid     = 1'b0;
      m_ready     = 1'b0;
   endtask

   // One clock: drive inputs, take the edge, update the model, settle.
   task automatic tick(input logic sv, input logic [63:0] s, input logic en);
      seed_valid = sv;
      seed       = s;
      enable     = en;
      @(posedge clk);
      if (rst_n) begin
         if (sv && m_ready) begin
            m_lfsr      = (s == 64'h0) ? 64'h1 : s;
            m_warm_left = WU;
            m_valid     = 1'b0;
         end else if (m_warm_left > 0) begin
            m_lfsr      = model_advance(m_lfsr);
            m_warm_left = m_warm_left - 1;
            m_valid     = (m_warm_left == 0);
         end else if (m_valid && en) begin
            m_lfsr = model_advance(m_lfsr);
         end
         m_ready = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         tick(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         n_cmp++;
         if ({valid, seed_ready, p, r} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold i=%0d got valid=%b ready=%b p=%h r=%h exp all zero",
                     i, valid, seed_ready, p, r);
         end
      end
      rst_n = 1'b1;
      tick(1'b0, 64'h0, 1'b0);
      n_cmp++;
      if (seed_ready !== 1'b1 || valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0",
                  seed_ready, valid);
      end
   endtask

   task automatic test_seed_warmup();
      tick(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
      for (int i = 1; i <= int'(WU); i++) begin
         tick(1'b0, 64'h0, 1'($urandom_range(0, 1)));
         n_cmp++;
         if (valid !== (i == int'(WU))) begin
            n_bad++;
            $display("FAIL warmup_timing edge=%0d got valid=%b exp %b", i, valid, i == int'(WU));
         end
         n_cmp++;
         if ({valid, seed_ready, p, r} !== {m_valid, m_ready, model_out()}) begin
            n_bad++;
            $display("FAIL warmup_model edge=%0d got v=%b rdy=%b pr=%h exp v=%b rdy=%b pr=%h",
                     i, valid, seed_ready, {p, r}, m_valid, m_ready, model_out());
         end
      end
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 64'h0, 1'b1);
         n_cmp++;
         if ({valid, p, r} !== {m_valid, model_out()}) begin
            n_bad++;
            $display("FAIL run_stream i=%0d got v=%b pr=%h exp v=%b pr=%h",
                     i, valid, {p, r}, m_valid, model_out());
         end
      end
   endtask

   task automatic test_hold();
      logic [K-1:0] snap;
      snap = model_out();
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 64'h0, 1'b0);
         n_cmp++;
         if ({valid, p, r} !== {1'b1, snap}) begin
            n_bad++;
            $display("FAIL hold i=%0d got v=%b pr=%h exp v=1 pr=%h", i, valid, {p, r}, snap);
         end
      end
      tick(1'b0, 64'h0, 1'b1);
      n_cmp++;
      if ({valid, p, r} !== {m_valid, model_out()}) begin
         n_bad++;
         $display("FAIL hold_resume got v=%b pr=%h exp v=%b pr=%h",
                  valid, {p, r}, m_valid, model_out());
      end
   endtask

   task automatic test_reseed_in_run();
      tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      n_cmp++;
      if (valid !== 1'b0 || {p, r} !== '0) begin
         n_bad++;
         $display("FAIL reseed_drop got v=%b pr=%h exp v=0 pr=0", valid, {p, r});
      end
      for (int i = 1; i <= int'(WU) + 10; i++) begin
         tick(1'b0, 64'h0, 1'b1);
         n_cmp++;
         if (valid !== (i >= int'(WU)) || {p, r} !== model_out()) begin
            n_bad++;
            $display("FAIL reseed_warmup edge=%0d got v=%b pr=%h exp v=%b pr=%h",
                     i, valid, {p, r}, i >= int'(WU), model_out());
         end
      end
   endtask

   task automatic test_zero_seed();
      logic [63:0] ref1;
      int          nz;
      ref1 = 64'h1;
      for (int i = 0; i < int'(WU); i++) ref1 = model_advance(ref1);
      tick(1'b1, 64'h0, 1'b0);
      for (int i = 0; i < int'(WU); i++) tick(1'b0, 64'h0, 1'b0);
      n_cmp++;
      if ({valid, p, r} !== {1'b1, ref1[K-1:0]}) begin
         n_bad++;
         $display("FAIL zero_seed_as_one got v=%b pr=%h exp v=1 pr=%h",
                  valid, {p, r}, ref1[K-1:0]);
      end
      nz = 0;
      for (int i = 0; i < 1000; i++) begin
         tick(1'b0, 64'h0, 1'b1);
         if ({p, r} != '0) nz++;
         n_cmp++;
         if ({valid, p, r} !== {m_valid, model_out()}) begin
            n_bad++;
            $display("FAIL zero_seed_stream i=%0d got v=%b pr=%h exp v=%b pr=%h",
                     i, valid, {p, r}, m_valid, model_out());
         end
      end
      n_cmp++;
      if (nz < 500) begin
         n_bad++;
         $display("FAIL zero_seed_nonzero got %0d nonzero outputs exp at least 500", nz);
      end
   endtask

   task automatic test_reset_mid_warmup();
      tick(1'b1, {$urandom, $urandom}, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 64'h0, 1'b1);
      apply_reset();
      #2;
      n_cmp++;
      if ({valid, seed_ready, p, r} !== '0) begin
         n_bad++;
         $display("FAIL async_reset got v=%b rdy=%b p=%h r=%h exp all zero",
                  valid, seed_ready, p, r);
      end
      for (int i = 0; i < 3; i++) tick(1'b1, {$urandom, $urandom}, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 64'h0, 1'($urandom_range(0, 1)));
         n_cmp++;
         if ({valid, p, r} !== '0 || seed_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL unseeded i=%0d got v=%b rdy=%b pr=%h exp v=0 rdy=1 pr=0",
                     i, valid, seed_ready, {p, r});
         end
      end
      tick(1'b1, {$urandom, $urandom}, 1'b0);
      for (int i = 1; i <= int'(WU) + 5; i++) begin
         tick(1'b0, 64'h0, 1'b1);
         n_cmp++;
         if ({valid, p, r} !== {m_valid, model_out()}) begin
            n_bad++;
            $display("FAIL reseed_after_reset edge=%0d got v=%b pr=%h exp v=%b pr=%h",
                     i, valid, {p, r}, m_valid, model_out());
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] s;
      logic        sv;
      for (int i = 0; i < 400; i++) begin
         sv = ($urandom_range(0, 19) == 0);
         s  = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
         tick(sv, s, 1'($urandom_range(0, 1)));
         n_cmp++;
         if ({valid, seed_ready, p, r} !== {m_valid, m_ready, model_out()}) begin
            n_bad++;
            $display("FAIL random i=%0d got v=%b rdy=%b pr=%h exp v=%b rdy=%b pr=%h",
                     i, valid, seed_ready, {p, r}, m_valid, m_ready, model_out());
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      seed       = '0;
      seed_valid = 1'b0;
      enable     = 1'b0;
      #2;
      test_reset();
      test_seed_warmup();
      test_hold();
      test_reseed_in_run();
      test_zero_seed();
      test_reset_mid_warmup();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
